// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access pipeline stage.
// State, cache-control and access-width codes.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        dcc_none  = 2'b00,
        dcc_load  = 2'b01,
        dcc_store = 2'b10
    } dcc_t;

    typedef enum logic [1:0] {
        ty_byte = 2'b00,
        ty_half = 2'b01,
        ty_word = 2'b10
    } acc_ty_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the memory stage: store strobes/data,
// load extraction/extension and misalignment detection.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  acc_type,
    input  logic [1:0]  acc_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned,
    input  logic [1:0]  ld_type,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = st_data;
        misaligned = 1'b0;
        unique case (1'b1)
            acc_type == ty_byte: begin
                wstrb = 4'b0001 << acc_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            acc_type == ty_half: begin
                wstrb      = acc_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{st_data[15:0]}};
                misaligned = acc_addr_lo[0];
            end
            default: begin
                wstrb      = 4'b1111;
                wdata      = st_data;
                misaligned = |acc_addr_lo;
            end
        endcase
    end

    assign ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = rdata[{ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = rdata;
        unique case (1'b1)
            ld_type == ty_byte:
                ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            ld_type == ty_half:
                ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default:
                ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: data-cache handshake, upstream
// stall while an access is outstanding, registered write-back.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            VALID_IN,
    input  logic            FLUSH_I,
    input  logic [XLEN-1:0] WB_DATA_EX,
    input  logic [XLEN-1:0] DATA_ADDRESS,
    input  logic [XLEN-1:0] STORE_DATA,
    input  logic [1:0]      DATA_CACHE_CONTROL,
    input  logic [1:0]      TYPE_IN,
    input  logic            LOAD_UNSIGNED,
    input  logic [4:0]      RD_IN,
    input  logic            RD_WE_IN,
    output logic            DC_REQ,
    output logic            DC_WR,
    output logic [XLEN-1:0] DC_ADDR,
    output logic [3:0]      DC_WSTRB,
    output logic [XLEN-1:0] DC_WDATA,
    input  logic [XLEN-1:0] DC_RDATA,
    input  logic            DC_READY,
    output logic            STALL_OUT,
    output logic            WB_VALID,
    output logic [4:0]      WB_RD,
    output logic            WB_WE,
    output logic [XLEN-1:0] WB_DATA,
    output logic            MISALIGNED,
    output logic            DC_TIMEOUT
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_t state, state_n;

    logic [XLEN-1:0]  addr_q;
    logic [1:0]       addr_lo_q;
    logic [1:0]       ty_q;
    logic             uns_q;
    logic [4:0]       rd_q;
    logic             we_q;
    logic             wr_q;
    logic [3:0]       wstrb_q;
    logic [XLEN-1:0]  wdata_q;
    logic [CNT_W-1:0] tmo_cnt;

    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic             wb_we_q;
    logic [XLEN-1:0]  wb_data_q;
    logic             mis_q;
    logic             tmo_q;

    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata;
    logic             st_mis;
    logic [31:0]      ld_data;

    logic is_load, is_store, is_mem;
    logic accept, go_alu, go_mis, go_wait;
    logic in_wait, done, tmo_hit, tmo_fire;

    mem_align u_align (
        .acc_type    (TYPE_IN),
        .acc_addr_lo (DATA_ADDRESS[1:0]),
        .st_data     (STORE_DATA),
        .wstrb       (st_wstrb),
        .wdata       (st_wdata),
        .misaligned  (st_mis),
        .ld_type     (ty_q),
        .ld_addr_lo  (addr_lo_q),
        .ld_unsigned (uns_q),
        .rdata       (DC_RDATA),
        .ld_data     (ld_data)
    );

    assign is_load  = (DATA_CACHE_CONTROL == dcc_load);
    assign is_store = (DATA_CACHE_CONTROL == dcc_store);
    assign is_mem   = is_load | is_store;

    assign accept  = VALID_IN & ~FLUSH_I & (state == ST_IDLE);
    assign go_alu  = accept & ~is_mem;
    assign go_mis  = accept & is_mem & st_mis;
    assign go_wait = accept & is_mem & ~st_mis;

    assign in_wait  = (state == ST_WAIT);
    assign done     = in_wait & DC_READY;
    assign tmo_hit  = (TIMEOUT_CYCLES > 0) &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_fire = in_wait & ~DC_READY & tmo_hit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (go_wait) state_n = ST_WAIT;
            ST_WAIT: if (done || tmo_fire) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q    <= '0;
            addr_lo_q <= 2'b00;
            ty_q      <= 2'b00;
            uns_q     <= 1'b0;
            rd_q      <= 5'd0;
            we_q      <= 1'b0;
            wr_q      <= 1'b0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= '0;
        end else if (go_wait) begin
            addr_q    <= {DATA_ADDRESS[XLEN-1:2], 2'b00};
            addr_lo_q <= DATA_ADDRESS[1:0];
            ty_q      <= TYPE_IN;
            uns_q     <= LOAD_UNSIGNED;
            rd_q      <= RD_IN;
            we_q      <= RD_WE_IN;
            wr_q      <= is_store;
            wstrb_q   <= is_store ? st_wstrb : 4'b0000;
            wdata_q   <= st_wdata;
        end
    end

    // Counts WAIT cycles without DC_READY; cleared on exit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            tmo_cnt <= '0;
        else if (TIMEOUT_CYCLES > 0 && in_wait &&
                 !DC_READY && !tmo_fire)
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            tmo_q      <= 1'b0;
            if (go_alu) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= RD_IN;
                wb_we_q    <= RD_WE_IN;
                wb_data_q  <= WB_DATA_EX;
            end else if (go_mis) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= RD_IN;
                wb_we_q    <= 1'b0;
                wb_data_q  <= DATA_ADDRESS;
                mis_q      <= 1'b1;
            end else if (done) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_we_q    <= we_q & ~wr_q;
                if (!wr_q) wb_data_q <= ld_data;
            end else if (tmo_fire) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_we_q    <= 1'b0;
                tmo_q      <= 1'b1;
            end
        end
    end

    assign DC_REQ     = in_wait;
    assign STALL_OUT  = in_wait;
    assign DC_WR      = wr_q;
    assign DC_ADDR    = addr_q;
    assign DC_WSTRB   = wstrb_q;
    assign DC_WDATA   = wdata_q;

    assign WB_VALID   = wb_valid_q;
    assign WB_RD      = wb_rd_q;
    assign WB_WE      = wb_we_q;
    assign WB_DATA    = wb_data_q;
    assign MISALIGNED = mis_q;
    assign DC_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a small
// latency-programmable data-cache responder.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        VALID_IN = 1'b0;
    logic        FLUSH_I = 1'b0;
    logic [31:0] WB_DATA_EX = '0;
    logic [31:0] DATA_ADDRESS = '0;
    logic [31:0] STORE_DATA = '0;
    logic [1:0]  DATA_CACHE_CONTROL = 2'b00;
    logic [1:0]  TYPE_IN = 2'b00;
    logic        LOAD_UNSIGNED = 1'b0;
    logic [4:0]  RD_IN = '0;
    logic        RD_WE_IN = 1'b0;
    logic        DC_REQ, DC_WR;
    logic [31:0] DC_ADDR, DC_WDATA;
    logic [3:0]  DC_WSTRB;
    logic [31:0] DC_RDATA = '0;
    logic        DC_READY = 1'b0;
    logic        STALL_OUT, WB_VALID, WB_WE;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        MISALIGNED, DC_TIMEOUT;

    mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .VALID_IN(VALID_IN), .FLUSH_I(FLUSH_I),
        .WB_DATA_EX(WB_DATA_EX),
        .DATA_ADDRESS(DATA_ADDRESS),
        .STORE_DATA(STORE_DATA),
        .DATA_CACHE_CONTROL(DATA_CACHE_CONTROL),
        .TYPE_IN(TYPE_IN),
        .LOAD_UNSIGNED(LOAD_UNSIGNED),
        .RD_IN(RD_IN), .RD_WE_IN(RD_WE_IN),
        .DC_REQ(DC_REQ), .DC_WR(DC_WR),
        .DC_ADDR(DC_ADDR), .DC_WSTRB(DC_WSTRB),
        .DC_WDATA(DC_WDATA), .DC_RDATA(DC_RDATA),
        .DC_READY(DC_READY), .STALL_OUT(STALL_OUT),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .WB_WE(WB_WE), .WB_DATA(WB_DATA),
        .MISALIGNED(MISALIGNED),
        .DC_TIMEOUT(DC_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        mis;
        logic        tmo;
        logic        full;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   drv_cyc = 0;
    int   wb_cyc = 0;

    int          lat = 0;
    int          req_cnt = 0;
    int          req_len = 0;
    int          req_total = 0;
    int          stall_cnt = 0;
    int          stall_len = 0;
    logic        unstable = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [31:0] cap_wstrb = '0;
    logic [31:0] cap_wr = '0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Cache responder: ready after `lat` request cycles, 0 = never.
    always @(negedge CLK) begin
        if (DC_REQ) begin
            if (req_cnt == 0) begin
                cap_addr  = DC_ADDR;
                cap_wdata = DC_WDATA;
                cap_wstrb = {28'd0, DC_WSTRB};
                cap_wr    = {31'd0, DC_WR};
            end else if (DC_ADDR !== cap_addr ||
                         DC_WDATA !== cap_wdata ||
                         {28'd0, DC_WSTRB} !== cap_wstrb) begin
                unstable = 1'b1;
            end
            req_cnt++;
            req_total++;
            DC_READY = (lat != 0) && (req_cnt == lat);
        end else begin
            if (req_cnt != 0) req_len = req_cnt;
            req_cnt  = 0;
            DC_READY = 1'b0;
        end
        if (STALL_OUT) begin
            stall_cnt++;
        end else begin
            if (stall_cnt != 0) stall_len = stall_cnt;
            stall_cnt = 0;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && WB_VALID) begin
            wb_cyc = cyc;
            if (q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("wb_we", {31'd0, WB_WE}, {31'd0, e.we});
                chk("wb_mis", {31'd0, MISALIGNED},
                    {31'd0, e.mis});
                chk("wb_tmo", {31'd0, DC_TIMEOUT},
                    {31'd0, e.tmo});
                if (e.full) begin
                    chk("wb_rd", {27'd0, WB_RD}, {27'd0, e.rd});
                    chk("wb_data", WB_DATA, e.data);
                end
            end
        end
    end

    task automatic expect_wb(input logic [4:0] rd,
                             input logic we,
                             input logic [31:0] data,
                             input logic mis,
                             input logic tmo,
                             input logic full);
        exp_t e;
        e.rd = rd; e.we = we; e.data = data;
        e.mis = mis; e.tmo = tmo; e.full = full;
        q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] dcc,
                         input logic [1:0] ty,
                         input logic uns,
                         input logic [31:0] addr,
                         input logic [31:0] sd,
                         input logic [31:0] exd,
                         input logic [4:0] rd,
                         input logic we,
                         input logic fl);
        VALID_IN = 1'b1;
        FLUSH_I = fl;
        DATA_CACHE_CONTROL = dcc;
        TYPE_IN = ty;
        LOAD_UNSIGNED = uns;
        DATA_ADDRESS = addr;
        STORE_DATA = sd;
        WB_DATA_EX = exd;
        RD_IN = rd;
        RD_WE_IN = we;
        unstable = 1'b0;
        drv_cyc = cyc;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        FLUSH_I = 1'b0;
        DATA_CACHE_CONTROL = 2'b00;
    endtask

    task automatic settle();
        for (int i = 0; i < 40; i++) begin
            if (!STALL_OUT) break;
            @(posedge CLK); #1;
        end
        if (STALL_OUT) chk("settle_bound", 32'd1, 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int base;
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        #1;
        chk("rst_req", {31'd0, DC_REQ}, 32'd0);
        chk("rst_stall", {31'd0, STALL_OUT}, 32'd0);
        chk("rst_wbv", {31'd0, WB_VALID}, 32'd0);
        chk("rst_wbdata", WB_DATA, 32'd0);
        chk("rst_addr", DC_ADDR, 32'd0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        expect_wb(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
        issue(2'b00, 2'b10, 1'b0, 32'h0, 32'h0,
              32'h1234, 5'd5, 1'b1, 1'b0);
        chk("alu_stall", {31'd0, STALL_OUT}, 32'd0);
        settle();
        chk("alu_lat", wb_cyc - drv_cyc, 32'd1);

        lat = 3;
        DC_RDATA = 32'h80FF_0000;
        expect_wb(5'd6, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 2'b00, 1'b0, 32'h1003, 32'h0,
              32'h0, 5'd6, 1'b1, 1'b0);
        settle();
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_wr", cap_wr, 32'd0);
        chk("lb_wstrb", cap_wstrb, 32'd0);
        chk("lb_stall", stall_len, 32'd3);
        chk("lb_lat", wb_cyc - drv_cyc, 32'd4);

        expect_wb(5'd7, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 2'b00, 1'b1, 32'h1003, 32'h0,
              32'h0, 5'd7, 1'b1, 1'b0);
        VALID_IN = 1'b1;
        FLUSH_I = 1'b1;
        RD_IN = 5'd31;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        FLUSH_I = 1'b0;
        settle();
        chk("lbu_stall", stall_len, 32'd3);

        expect_wb(5'd8, 1'b1, 32'hFFFF_80FF, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 2'b01, 1'b0, 32'h1002, 32'h0,
              32'h0, 5'd8, 1'b1, 1'b0);
        settle();
        expect_wb(5'd9, 1'b1, 32'h0000_80FF, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 2'b01, 1'b1, 32'h1002, 32'h0,
              32'h0, 5'd9, 1'b1, 1'b0);
        settle();
        lat = 1;
        DC_RDATA = 32'h1234_7FFE;
        expect_wb(5'd10, 1'b1, 32'h0000_7FFE, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 2'b01, 1'b0, 32'h1000, 32'h0,
              32'h0, 5'd10, 1'b1, 1'b0);
        settle();
        chk("lh_lat", wb_cyc - drv_cyc, 32'd2);

        lat = 2;
        expect_wb(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 2'b01, 1'b0, 32'h2002, 32'hABCD_1234,
              32'h0, 5'd11, 1'b1, 1'b0);
        settle();
        chk("sh_wr", cap_wr, 32'd1);
        chk("sh_addr", cap_addr, 32'h2000);
        chk("sh_wstrb", cap_wstrb, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h1234_1234);
        chk("sh_stable", {31'd0, unstable}, 32'd0);

        expect_wb(5'd12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 2'b00, 1'b0, 32'h2001, 32'h0000_0056,
              32'h0, 5'd12, 1'b1, 1'b0);
        settle();
        chk("sb_wstrb", cap_wstrb, 32'h2);
        chk("sb_wdata", cap_wdata, 32'h5656_5656);

        expect_wb(5'd13, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 2'b11, 1'b0, 32'h2004, 32'hCAFE_F00D,
              32'h0, 5'd13, 1'b1, 1'b0);
        settle();
        chk("sw_addr", cap_addr, 32'h2004);
        chk("sw_wstrb", cap_wstrb, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);

        base = req_total;
        expect_wb(5'd14, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        issue(2'b01, 2'b10, 1'b0, 32'h3001, 32'h0,
              32'h0, 5'd14, 1'b1, 1'b0);
        settle();
        chk("lw_mis_lat", wb_cyc - drv_cyc, 32'd1);
        expect_wb(5'd15, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        issue(2'b10, 2'b01, 1'b0, 32'h3003, 32'h0,
              32'h0, 5'd15, 1'b1, 1'b0);
        settle();
        issue(2'b01, 2'b10, 1'b0, 32'h3000, 32'h0,
              32'h0, 5'd16, 1'b1, 1'b1);
        settle();
        chk("nomem_req", req_total - base, 32'd0);

        expect_wb(5'd17, 1'b1, 32'h0BAD_BEEF, 1'b0, 1'b0, 1'b1);
        issue(2'b11, 2'b10, 1'b0, 32'h3000, 32'h0,
              32'h0BAD_BEEF, 5'd17, 1'b1, 1'b0);
        settle();
        chk("dcc11_req", req_total - base, 32'd0);

        lat = 0;
        issue(2'b01, 2'b10, 1'b0, 32'h5000, 32'h0,
              32'h0, 5'd18, 1'b1, 1'b0);
        @(posedge CLK); #1;
        chk("pre_rst_req", {31'd0, DC_REQ}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("wrst_req", {31'd0, DC_REQ}, 32'd0);
        chk("wrst_stall", {31'd0, STALL_OUT}, 32'd0);
        chk("wrst_addr", DC_ADDR, 32'd0);
        chk("wrst_wbdata", WB_DATA, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        expect_wb(5'd19, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(2'b01, 2'b10, 1'b0, 32'h4000, 32'h0,
              32'h0, 5'd19, 1'b1, 1'b0);
        settle();
        chk("tmo_req_len", req_len, 32'd4);
        chk("tmo_lat", wb_cyc - drv_cyc, 32'd5);
        chk("tmo_idle", {31'd0, STALL_OUT}, 32'd0);

        lat = 1;
        DC_RDATA = 32'hDEAD_BEEF;
        expect_wb(5'd20, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 2'b10, 1'b0, 32'h6000, 32'h0,
              32'h0, 5'd20, 1'b1, 1'b0);
        settle();
        chk("lw_stall", stall_len, 32'd1);

        expect_wb(5'd21, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b1);
        expect_wb(5'd22, 1'b0, 32'h0000_00AA, 1'b0, 1'b0, 1'b1);
        VALID_IN = 1'b1;
        WB_DATA_EX = 32'h55; RD_IN = 5'd21; RD_WE_IN = 1'b1;
        @(posedge CLK); #1;
        WB_DATA_EX = 32'hAA; RD_IN = 5'd22; RD_WE_IN = 1'b0;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        chk("sb_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
